// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the core's instruction-fetch path and
// its load/store path. One transaction is in flight at a time; when both
// requesters ask at once, the one not served last wins (round-robin).
//
// Ports
//   clk, rst                clock and synchronous active-high reset
//   i_instr_req/addr        instruction read request (held until o_instr_ack)
//   o_instr_ack/rdata       one-cycle completion pulse and fetched word
//   i_data_read_en/write_en data load / store request (store wins if both)
//   i_data_addr/write_data  data address and store data
//   i_data_wstrb            store byte enables
//   o_data_ack/rdata        one-cycle completion pulse and load data
//   o_mem_valid/i_mem_ready memory request handshake
//   o_mem_we/addr/wdata/wstrb  memory request fields (wstrb is 0 for reads)
//   i_mem_rvalid/rdata      memory read response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_instr_req,
    input  logic [ADDR_W-1:0]   i_instr_addr,
    output logic                o_instr_ack,
    output logic [DATA_W-1:0]   o_instr_rdata,

    input  logic                i_data_read_en,
    input  logic                i_data_write_en,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_write_data,
    input  logic [DATA_W/8-1:0] i_data_wstrb,
    output logic                o_data_ack,
    output logic [DATA_W-1:0]   o_data_rdata,

    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    grant_t              grant_q, grant_d;
    grant_t              pick;
    logic                data_req;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                instr_ack_q, instr_ack_d;
    logic                data_ack_q, data_ack_d;
    logic [DATA_W-1:0]   instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        instr_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        data_req      = i_data_read_en | i_data_write_en;
        pick          = GNT_INSTR;

        case (state_q)
            S_IDLE: begin
                if (i_instr_req || data_req) begin
                    if (i_instr_req && data_req)
                        pick = (last_grant_q == GNT_DATA) ? GNT_INSTR : GNT_DATA;
                    else
                        pick = i_instr_req ? GNT_INSTR : GNT_DATA;

                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = S_ISSUE;

                    if (pick == GNT_INSTR) begin
                        we_d    = 1'b0;
                        addr_d  = i_instr_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end else begin
                        // A store wins over a load when both enables are up.
                        we_d    = i_data_write_en;
                        addr_d  = i_data_addr;
                        wdata_d = i_data_write_en ? i_data_write_data : '0;
                        wstrb_d = i_data_write_en ? i_data_wstrb : '0;
                    end
                end
            end

            S_ISSUE: begin
                if (i_mem_ready) begin
                    if (we_q) begin
                        // Stores have no response phase; acknowledge next.
                        state_d     = S_DONE;
                        instr_ack_d = (grant_q == GNT_INSTR);
                        data_ack_d  = (grant_q == GNT_DATA);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d     = S_DONE;
                    instr_ack_d = (grant_q == GNT_INSTR);
                    data_ack_d  = (grant_q == GNT_DATA);
                    if (grant_q == GNT_INSTR)
                        instr_rdata_d = i_mem_rdata;
                    else
                        data_rdata_d = i_mem_rdata;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GNT_DATA;   // first tie goes to instruction
            grant_q       <= GNT_INSTR;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            instr_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            instr_ack_q   <= instr_ack_d;
            data_ack_q    <= data_ack_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    // Valid and write flag decode from state and request registers only.
    assign o_mem_valid   = (state_q == S_ISSUE);
    assign o_mem_we      = (state_q == S_ISSUE) && we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_mem_wstrb   = wstrb_q;
    assign o_instr_ack   = instr_ack_q;
    assign o_data_ack    = data_ack_q;
    assign o_instr_rdata = instr_rdata_q;
    assign o_data_rdata  = data_rdata_q;

endmodule
